// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : regfile_wb_arbiter_pkg
// Description : Shared types and constants for the regfile write-back arbiter
//               and its mdu result buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  i4;
    typedef logic [4:0]  creg_addr_t;

    // Depth of the mdu result buffer; pointers are one bit wide because of it.
    localparam int c_FIFO_DEPTH = 2;

    // Head age at which the arbiter asks the pipeline to yield the port.
    localparam logic [2:0] c_AGE_STALL = 3'd6;

    // One buffered long-latency write.
    typedef struct packed {
        creg_addr_t addr;
        word_t      data;
    } wb_entry_t;

    // Which source owns the regfile write port in the current cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;

    // One-hot decode of a register address into a 32-bit mask.
    function automatic logic [31:0] addr_onehot(input creg_addr_t addr);
        return 32'd1 << addr;
    endfunction

endpackage : regfile_wb_arbiter_pkg
`default_nettype wire

// File: rtl/wb_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo2
// Description : Two-entry FIFO of pending mdu regfile writes. Exposes the
//               head entry plus per-slot valid/address so the parent can
//               build a busy mask of in-flight destinations.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          i_push,
    input  wb_entry_t                     i_push_entry,
    input  logic                          i_pop,
    output logic                          o_full,
    output logic                          o_empty,
    output wb_entry_t                     o_head,
    output logic [c_FIFO_DEPTH-1:0]       o_entry_valid,
    output creg_addr_t [c_FIFO_DEPTH-1:0] o_entry_addr
);

    wb_entry_t                r_mem [c_FIFO_DEPTH];
    logic                     r_wr_ptr;
    logic                     r_rd_ptr;
    logic [1:0]               r_count;
    logic [c_FIFO_DEPTH-1:0]  r_valid;

    logic w_push;
    logic w_pop;

    // A full buffer refuses pushes even when a pop frees a slot this cycle.
    assign o_full  = (r_count == 2'(c_FIFO_DEPTH));
    assign o_empty = (r_count == 2'd0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop  && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    for (genvar gi = 0; gi < c_FIFO_DEPTH; gi++) begin : g_entry
        assign o_entry_valid[gi] = r_valid[gi];
        assign o_entry_addr[gi]  = r_mem[gi].addr;
    end

    // Storage is data-path only; slot validity is tracked separately.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointers, occupancy and slot-valid flags; pointers wrap modulo 2.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr          <= ~r_wr_ptr;
                r_valid[r_wr_ptr] <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr          <= ~r_rd_ptr;
                r_valid[r_rd_ptr] <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : wb_fifo2
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the single regfile write port between W-stage writes
//               (always accepted, highest priority) and buffered mdu results.
//               Tracks head age and asks the pipeline to stall so buffered
//               results cannot starve.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic [3:0]  pipe_strobe,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic [4:0]  wa3,
    output logic [3:0]  write_enable,
    output logic [31:0] wd3,
    output logic [31:0] busy_mask,
    output logic        stall_req
);

    logic                          w_full;
    logic                          w_empty;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_pipe_sel;
    wb_entry_t                     w_head;
    logic [c_FIFO_DEPTH-1:0]       w_entry_valid;
    creg_addr_t [c_FIFO_DEPTH-1:0] w_entry_addr;
    wb_src_e                       w_src;
    logic [31:0]                   w_busy;

    logic [2:0]                    r_age;
    logic                          r_stall;
    logic [4:0]                    r_wa3;
    logic [3:0]                    r_we;
    logic [31:0]                   r_wd3;

    // Writes to r0 are swallowed at the door so they never occupy a slot.
    assign mdu_ready  = !w_full;
    assign w_push     = mdu_valid && !w_full && (mdu_addr != 5'd0);
    assign w_pipe_sel = pipe_valid && (pipe_strobe != 4'b0000);
    assign w_pop      = !w_pipe_sel && !w_empty;

    wb_fifo2 u_fifo (
        .clk           (clk),
        .resetn        (resetn),
        .i_push        (w_push),
        .i_push_entry  ('{addr: mdu_addr, data: mdu_data}),
        .i_pop         (w_pop),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_head        (w_head),
        .o_entry_valid (w_entry_valid),
        .o_entry_addr  (w_entry_addr)
    );

    // Port ownership: the pipeline always wins, the buffer fills idle slots.
    always_comb begin
        w_src = SRC_NONE;
        if (w_pipe_sel) begin
            w_src = SRC_PIPE;
        end else if (!w_empty) begin
            w_src = SRC_FIFO;
        end
    end

    // Destinations of every buffered write; r0 is never reported busy.
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < c_FIFO_DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                w_busy = w_busy | addr_onehot(w_entry_addr[i]);
            end
        end
    end

    assign busy_mask = {w_busy[31:1], 1'b0};

    // Registered write port; address/data hold when nothing is written.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wa3 <= 5'd0;
            r_we  <= 4'b0000;
            r_wd3 <= 32'd0;
        end else begin
            case (w_src)
                SRC_PIPE: begin
                    if (pipe_addr != 5'd0) begin
                        r_wa3 <= pipe_addr;
                        r_we  <= pipe_strobe;
                        r_wd3 <= pipe_data;
                    end else begin
                        r_we  <= 4'b0000;
                    end
                end
                SRC_FIFO: begin
                    if (w_head.addr != 5'd0) begin
                        r_wa3 <= w_head.addr;
                        r_we  <= 4'b1111;
                        r_wd3 <= w_head.data;
                    end else begin
                        r_we  <= 4'b0000;
                    end
                end
                default: r_we <= 4'b0000;
            endcase
        end
    end

    // Head age saturates at 7 and restarts whenever the head moves or vanishes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_age <= 3'd0;
        end else if (w_pop || w_empty) begin
            r_age <= 3'd0;
        end else if (r_age != 3'b111) begin
            r_age <= r_age + 3'd1;
        end
    end

    // Stall request one cycle after the buffer is full or its head is stale.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stall <= 1'b0;
        end else begin
            r_stall <= w_full || (r_age >= c_AGE_STALL);
        end
    end

    assign wa3          = r_wa3;
    assign write_enable = r_we;
    assign wd3          = r_wd3;
    assign stall_req    = r_stall;

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. A behavioural
//               model predicts each port write into a scoreboard queue; a
//               monitor pops and compares whenever the port writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pipe_valid;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic [3:0]  pipe_strobe;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic [4:0]  wa3;
    logic [3:0]  write_enable;
    logic [31:0] wd3;
    logic [31:0] busy_mask;
    logic        stall_req;

    typedef struct packed {
        logic [4:0]  addr;
        logic [3:0]  we;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    wr_t  sb[$];
    ent_t mq[$];
    int   m_age    = 0;
    logic m_stall  = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;
    int   k;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .resetn       (resetn),
        .pipe_valid   (pipe_valid),
        .pipe_addr    (pipe_addr),
        .pipe_data    (pipe_data),
        .pipe_strobe  (pipe_strobe),
        .mdu_valid    (mdu_valid),
        .mdu_addr     (mdu_addr),
        .mdu_data     (mdu_data),
        .mdu_ready    (mdu_ready),
        .wa3          (wa3),
        .write_enable (write_enable),
        .wd3          (wd3),
        .busy_mask    (busy_mask),
        .stall_req    (stall_req)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i].addr] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // Every port write must be the next one the model predicted.
    always @(negedge clk) begin
        wr_t e;
        if (mon_en && write_enable !== 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {wa3, write_enable, wd3}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("port_write", {wa3, write_enable, wd3}, e);
            end
        end
    end

    // One clock of stimulus: check live outputs mid-cycle, advance the model.
    task automatic cycle();
        bit   sel_pipe, was_empty, do_pop, ready, nxt_stall;
        ent_t e;
        @(negedge clk);
        if (mon_en) begin
            check("mdu_ready", mdu_ready, mq.size() < 2);
            check("busy_mask", busy_mask, model_mask());
            check("stall_req", stall_req, m_stall);
        end
        #1;
        if (!resetn) begin
            mq.delete();
            m_age   = 0;
            m_stall = 1'b0;
        end else begin
            sel_pipe  = pipe_valid && (pipe_strobe != 4'b0000);
            was_empty = (mq.size() == 0);
            ready     = (mq.size() < 2);
            nxt_stall = (mq.size() == 2) || (m_age >= 6);
            do_pop    = !sel_pipe && !was_empty;
            if (sel_pipe) begin
                if (pipe_addr != 5'd0) sb.push_back(wr_t'{pipe_addr, pipe_strobe, pipe_data});
            end else if (do_pop) begin
                e = mq.pop_front();
                sb.push_back(wr_t'{e.addr, 4'hF, e.data});
            end
            if (do_pop || was_empty) m_age = 0;
            else if (m_age < 7) m_age++;
            if (mdu_valid && ready && mdu_addr != 5'd0) mq.push_back(ent_t'{mdu_addr, mdu_data});
            m_stall = nxt_stall;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; pipe_valid = 1'b0; pipe_addr = '0; pipe_data = '0; pipe_strobe = '0;
        mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Reset state
        check("rst_wa3", wa3, 0);
        check("rst_we", write_enable, 0);
        check("rst_wd3", wd3, 0);
        check("rst_stall", stall_req, 0);
        check("rst_ready", mdu_ready, 1);
        check("rst_busy", busy_mask, 0);
        mon_en = 1'b1;

        // Pipe write, one-cycle latency
        pipe_valid = 1; pipe_addr = 5; pipe_strobe = 4'hF; pipe_data = 32'hDEADBEEF;
        cycle();
        check("pipe_wa3", wa3, 5);
        check("pipe_we", write_enable, 4'hF);
        check("pipe_wd3", wd3, 32'hDEADBEEF);

        // Partial strobe, then r0 write which must not enable and must hold wa3/wd3
        pipe_addr = 9; pipe_strobe = 4'b0011; pipe_data = 32'h55;
        cycle();
        check("pipe_part_we", write_enable, 4'b0011);
        pipe_addr = 0; pipe_strobe = 4'hF; pipe_data = 32'h99;
        cycle();
        pipe_valid = 0;
        check("pipe_r0_we", write_enable, 0);
        check("pipe_r0_wa3_hold", wa3, 9);
        check("pipe_r0_wd3_hold", wd3, 32'h55);
        cycle();

        // mdu write into an idle arbiter: busy at T+1, port at T+2
        mdu_valid = 1; mdu_addr = 7; mdu_data = 32'h12;
        check("idle_ready", mdu_ready, 1);
        cycle();
        mdu_valid = 0;
        check("idle_busy7_set", busy_mask[7], 1);
        check("idle_no_write_yet", write_enable, 0);
        cycle();
        check("idle_wa3", wa3, 7);
        check("idle_we", write_enable, 4'hF);
        check("idle_wd3", wd3, 32'h12);
        check("idle_busy7_clr", busy_mask[7], 0);
        cycle();

        // mdu write to r0 is accepted and dropped
        mdu_valid = 1; mdu_addr = 0; mdu_data = 32'hBAD;
        cycle();
        mdu_valid = 0;
        check("z_busy", busy_mask, 0);
        check("z_ready", mdu_ready, 1);
        cycle();
        check("z_we", write_enable, 0);

        // Pipe strobe 0 does not claim the port; buffered write drains
        mdu_valid = 1; mdu_addr = 15; mdu_data = 32'hF5;
        pipe_valid = 1; pipe_addr = 15; pipe_strobe = 4'b0000;
        cycle();
        mdu_valid = 0;
        cycle();
        pipe_valid = 0;
        check("s0_wa3", wa3, 15);
        check("s0_we", write_enable, 4'hF);
        cycle();

        // Contention: two pushes under continuous pipe traffic
        pipe_valid = 1; pipe_strobe = 4'hF; pipe_addr = 10; pipe_data = 100;
        mdu_valid = 1; mdu_addr = 3; mdu_data = 33;
        cycle();
        pipe_data = 101; mdu_addr = 4; mdu_data = 44;
        cycle();
        mdu_valid = 0; pipe_data = 102;
        check("c_ready_full", mdu_ready, 0);
        check("c_busy", busy_mask, 32'h18);
        cycle();
        check("c_stall", stall_req, 1);
        // Full with a pop this cycle: the r6 push must still be refused
        pipe_valid = 0; mdu_valid = 1; mdu_addr = 6; mdu_data = 66;
        check("c_ready_fullpop", mdu_ready, 0);
        cycle();
        mdu_valid = 0;
        check("c_first_wa3", wa3, 3);
        check("c_first_wd3", wd3, 33);
        check("c_busy_after_pop", busy_mask, 32'h10);
        cycle();
        check("c_second_wa3", wa3, 4);
        check("c_second_wd3", wd3, 44);
        check("c_busy_empty", busy_mask, 0);
        repeat (3) cycle();

        // Aging: one entry starved by pipe traffic until stall_req asserts
        pipe_valid = 1; pipe_addr = 20; pipe_strobe = 4'hF; pipe_data = 200;
        mdu_valid = 1; mdu_addr = 12; mdu_data = 32'hC0DE;
        cycle();
        mdu_valid = 0;
        k = 1;
        while (stall_req !== 1'b1 && k < 12) begin
            pipe_data = pipe_data + 1;
            cycle();
            k++;
        end
        check("a_stall_cycle", k, 8);
        pipe_valid = 0;
        cycle();
        check("a_drain_wa3", wa3, 12);
        check("a_drain_wd3", wd3, 32'hC0DE);
        check("a_drain_busy", busy_mask, 0);
        repeat (2) cycle();
        check("a_stall_clear", stall_req, 0);

        // Reset with two entries queued: nothing drains afterwards
        pipe_valid = 1; pipe_addr = 11; pipe_strobe = 4'hF; pipe_data = 32'h111;
        mdu_valid = 1; mdu_addr = 1; mdu_data = 32'hA1;
        cycle();
        mdu_addr = 2; mdu_data = 32'hA2;
        cycle();
        mdu_valid = 0;
        check("r_busy_pre", busy_mask, 32'h6);
        pipe_valid = 0; resetn = 0;
        cycle();
        resetn = 1;
        check("r_we", write_enable, 0);
        check("r_wa3", wa3, 0);
        check("r_wd3", wd3, 0);
        check("r_ready", mdu_ready, 1);
        check("r_busy", busy_mask, 0);
        check("r_stall", stall_req, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("r_no_drain", write_enable, 0);
        end

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
